tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of the team's 4-channel select-rotation mux path.
- Takes a 1-bit time-division-multiplexed stream with slots a, b, c, d in rotating order, plus a frame marker on slot a.
- Reconstructs one WORD_W-bit parallel word per channel.
- Presents the four words together with a single-cycle valid strobe, plus lock and error status for the link.

Parameters:
WORD_W, 8, bits per channel word; legal range 2..32; one bit per channel per frame, MSB first.

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  1  serial TDM data bit
din_valid  input  1  din carries a slot sample this cycle; cycles with din_valid=0 are ignored entirely
frame_sync  input  1  qualified by din_valid; marks the slot-a (slot 0) sample of a frame
out_a  output  WORD_W  channel a word (slot 0)
out_b  output  WORD_W  channel b word (slot 1)
out_c  output  WORD_W  channel c word (slot 2)
out_d  output  WORD_W  channel d word (slot 3)
word_valid  output  1  one-cycle strobe: out_a..out_d updated with a complete new set
locked  output  1  high while in LOCKED state
sync_err  output  1  one-cycle strobe on framing violation

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_a..out_d=0, word_valid=0, locked=0, sync_err=0.
  - State=HUNT, slot counter=0, bit counter=0, shift registers=0.
  - Reset mid-word discards all partial data.
- Internal state:
  - 2-bit slot counter, 0..3, wraps 3->0.
  - Bit counter, 0..WORD_W-1; increments after the slot-3 sample and wraps to 0 after a word completes.
  - Four WORD_W-bit shift registers; each sample shifts in at the LSB, so the first-received bit ends up as the MSB.
- HUNT state:
  - Samples without frame_sync are dropped; no output change.
  - A sample with din_valid=1 and frame_sync=1 is taken as slot 0, bit 0. It shifts into reg a, slot becomes 1, bit counter becomes 0, state becomes LOCKED, and locked=1 from the next cycle.
- LOCKED state, for each sample with din_valid=1:
  - slot==0 and frame_sync=1: normal. Shift into reg a, slot becomes 1.
  - slot==0 and frame_sync=0 (missing marker):
    - sync_err pulses.
    - State becomes HUNT, locked=0, partial words and bit counter cleared, sample dropped.
  - slot!=0 and frame_sync=1 (early marker):
    - sync_err pulses.
    - Partial words discarded, bit counter cleared.
    - The sample is taken as slot 0, bit 0 (realign); state stays LOCKED, slot becomes 1.
  - slot!=0 and frame_sync=0: normal. Shift into reg[slot], slot increments.
- Word completion:
  - Occurs on the edge that captures the slot-3 sample while bit counter==WORD_W-1.
  - On that same edge, out_a..out_c load their completed registers and out_d loads reg d with the incoming bit already shifted in.
  - word_valid=1 for exactly the following cycle.
  - Latency: outputs are visible one cycle after the final sample is presented.
- Outputs hold their value between strobes. They are not cleared by sync_err or by a return to HUNT; only rst_n clears them.
- Gaps in din_valid of any length stall all counters; there is no timeout.
- sync_err and word_valid never assert in the same cycle, since a violation always discards the word.
- Receiving frame_sync on every frame is mandatory.

Test Plan:
- Basic word, WORD_W=8, din_valid continuous: send 8 frames carrying a=0xA5, b=0x3C, c=0xFF, d=0x01 MSB first, frame_sync on each slot-0 sample -> locked=1 from cycle 2; word_valid single pulse one cycle after the 32nd sample; outputs equal those values; sync_err never asserts.
- Back-to-back and gapped: two consecutive words 0x12/0x34/0x56/0x78 then 0x9A/0xBC/0xDE/0xF0, din_valid deasserted randomly 0-5 cycles between samples -> exactly two word_valid pulses; correct values; outputs hold between pulses.
- Pre-sync garbage: 13 random samples with frame_sync=0, then a valid 8-frame word -> no word_valid or sync_err during garbage; locked rises only at the first frame_sync; word decodes correctly.
- Early marker: frame_sync asserted on slot 2 during frame 4 -> sync_err one pulse; locked stays 1; a fresh 8-frame word starting at that sample decodes correctly; no word_valid for the broken word.
- Missing marker: frame_sync absent at slot 0 of frame 3 -> sync_err pulse; locked=0 next cycle; previous out_* unchanged; relock on the next frame_sync and a full word decodes.
- Reset mid-word: assert rst_n=0 after frame 5 -> all outputs 0 immediately (asynchronous); after release, a new full word decodes with no residue from pre-reset bits.

Source files
------------

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Receive side of the 4-slot select-rotation TDM link. It
//               recovers one WORD_W-bit word per channel (a, b, c, d) from a
//               1-bit slot-rotating stream carrying a frame marker on slot a.
//               It presents the four words with a one-cycle valid strobe,
//               along with lock and framing-error status.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WORD_W-1:0] out_a,
  output logic [WORD_W-1:0] out_b,
  output logic [WORD_W-1:0] out_c,
  output logic [WORD_W-1:0] out_d,
  output logic              word_valid,
  output logic              locked,
  output logic              sync_err
);

  // Bit counter width; WORD_W is at least 2, so this is at least 1 bit.
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Index of the final bit position of a word.
  localparam logic [BW-1:0] C_LAST_BIT = BW'(WORD_W - 1);

  // Zero word used to clear shift registers and to seed the first bit.
  localparam logic [WORD_W-1:0] C_ZERO = '0;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_slot;
  logic [BW-1:0]     r_bit;
  logic [WORD_W-1:0] r_sh_a;
  logic [WORD_W-1:0] r_sh_b;
  logic [WORD_W-1:0] r_sh_c;
  logic [WORD_W-1:0] r_sh_d;

  // Each sample enters at the LSB, so the first bit received ends up as the MSB.
  logic [WORD_W-1:0] w_next_a;
  logic [WORD_W-1:0] w_next_b;
  logic [WORD_W-1:0] w_next_c;
  logic [WORD_W-1:0] w_next_d;
  logic [WORD_W-1:0] w_seed;
  logic              w_last_bit;

  // Candidate shift-register values for the current sample.
  always_comb begin
    w_next_a   = {r_sh_a[WORD_W-2:0], din};
    w_next_b   = {r_sh_b[WORD_W-2:0], din};
    w_next_c   = {r_sh_c[WORD_W-2:0], din};
    w_next_d   = {r_sh_d[WORD_W-2:0], din};
    w_seed     = {C_ZERO[WORD_W-2:0], din};
    w_last_bit = (r_bit == C_LAST_BIT);
  end

  // Framing FSM: slot/bit counters, channel shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_slot     <= 2'd0;
      r_bit      <= '0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_sh_c     <= '0;
      r_sh_d     <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      out_d      <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // Both strobes last one cycle unless this sample re-asserts them.
      word_valid <= 1'b0;
      sync_err   <= 1'b0;

      // Cycles without din_valid leave every counter and register untouched.
      if (din_valid) begin
        case (r_state)
          ST_HUNT: begin
            // Drop everything until a marker shows where slot a is.
            if (frame_sync) begin
              r_sh_a  <= w_seed;
              r_slot  <= 2'd1;
              r_bit   <= '0;
              r_state <= ST_LOCKED;
              locked  <= 1'b1;
            end
          end

          ST_LOCKED: begin
            if (r_slot == 2'd0) begin
              if (frame_sync) begin
                r_sh_a <= w_next_a;
                r_slot <= 2'd1;
              end else begin
                // Missing marker: the framing is lost, so drop the sample
                // and go back to hunting from clean state.
                sync_err <= 1'b1;
                r_state  <= ST_HUNT;
                locked   <= 1'b0;
                r_slot   <= 2'd0;
                r_bit    <= '0;
                r_sh_a   <= '0;
                r_sh_b   <= '0;
                r_sh_c   <= '0;
                r_sh_d   <= '0;
              end
            end else if (frame_sync) begin
              // Early marker: stay locked but realign on this sample as
              // slot a, bit 0. The broken word is discarded.
              sync_err <= 1'b1;
              r_sh_a   <= w_seed;
              r_sh_b   <= '0;
              r_sh_c   <= '0;
              r_sh_d   <= '0;
              r_slot   <= 2'd1;
              r_bit    <= '0;
            end else begin
              r_slot <= r_slot + 2'd1;
              case (r_slot)
                2'd1:    r_sh_b <= w_next_b;
                2'd2:    r_sh_c <= w_next_c;
                default: begin
                  r_sh_d <= w_next_d;
                  if (w_last_bit) begin
                    // Word complete. out_d takes the bit that arrives now.
                    out_a      <= r_sh_a;
                    out_b      <= r_sh_b;
                    out_c      <= r_sh_c;
                    out_d      <= w_next_d;
                    word_valid <= 1'b1;
                    r_bit      <= '0;
                  end else begin
                    r_bit <= r_bit + BW'(1);
                  end
                end
              endcase
            end
          end

          default: begin
            r_state <= ST_HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Self-checking bench for tdm_demux4 (WORD_W = 8). A table of
//               word vectors is applied, followed by directed sequences for
//               pre-sync garbage, early and missing markers, and reset in
//               the middle of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int WORD_W = 8;

  logic              clk;
  logic              rst_n;
  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [WORD_W-1:0] out_a;
  logic [WORD_W-1:0] out_b;
  logic [WORD_W-1:0] out_c;
  logic [WORD_W-1:0] out_d;
  logic              word_valid;
  logic              locked;
  logic              sync_err;

  int checks;
  int errors;
  int n_wv;
  int n_err;

  tdm_demux4 #(.WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .word_valid (word_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses, sampling away from the active edge.
  always @(negedge clk) begin
    if (word_valid) n_wv = n_wv + 1;
    if (sync_err)   n_err = n_err + 1;
  end

  typedef struct {
    logic [31:0] w;      // {a, b, c, d} to transmit
    int          gap;    // max idle cycles inserted before each sample
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  ec;
    logic [7:0]  ed;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one input cycle, then let the edge happen and settle.
  task automatic step(input logic d, input logic dv, input logic fs);
    @(negedge clk);
    din        = d;
    din_valid  = dv;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  // Send samples [first, last) of word w. Slot = i%4 and bit = i/4, with the
  // MSB sent first. Idle cycles carry random din/frame_sync to show they are ignored.
  task automatic send_samples(input logic [31:0] w, input int gap, input int first, input int last);
    int slot;
    int bitn;
    int ng;
    for (int i = first; i < last; i++) begin
      ng = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
      for (int g = 0; g < ng; g++) step(1'($urandom), 1'b0, 1'($urandom));
      slot = i % 4;
      bitn = i / 4;
      step(w[(3 - slot) * 8 + (7 - bitn)], 1'b1, slot == 0);
    end
  endtask

  task automatic chk_outs(input string name, input logic [31:0] exp);
    chk({name, "_outs"}, {out_a, out_b, out_c, out_d}, exp);
  endtask

  // Send a full word and check the strobe and the decoded values.
  task automatic full_word(input string name, input logic [31:0] w, input int gap,
                           input logic [31:0] exp);
    int wv0;
    int er0;
    wv0 = n_wv;
    er0 = n_err;
    send_samples(w, gap, 0, 1);
    chk({name, "_locked_first"}, {31'd0, locked}, 32'd1);
    send_samples(w, gap, 1, 32);
    chk({name, "_wv_pulse"}, {31'd0, word_valid}, 32'd1);
    chk_outs(name, exp);
    step(1'b0, 1'b0, 1'b0);
    chk({name, "_wv_drop"}, {31'd0, word_valid}, 32'd0);
    chk({name, "_wv_count"}, n_wv - wv0, 32'd1);
    chk({name, "_err_count"}, n_err - er0, 32'd0);
  endtask

  vec_t vecs [5];
  int   wv0;
  int   er0;

  initial begin
    checks = 0;
    errors = 0;
    n_wv = 0;
    n_err = 0;
    din = 1'b0;
    din_valid = 1'b0;
    frame_sync = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{w: 32'hA53CFF01, gap: 0, ea: 8'hA5, eb: 8'h3C, ec: 8'hFF, ed: 8'h01};
    vecs[1] = '{w: 32'h12345678, gap: 5, ea: 8'h12, eb: 8'h34, ec: 8'h56, ed: 8'h78};
    vecs[2] = '{w: 32'h9ABCDEF0, gap: 5, ea: 8'h9A, eb: 8'hBC, ec: 8'hDE, ed: 8'hF0};
    vecs[3] = '{w: 32'h00FF00FF, gap: 0, ea: 8'h00, eb: 8'hFF, ec: 8'h00, ed: 8'hFF};
    vecs[4] = '{w: 32'h80017FFE, gap: 2, ea: 8'h80, eb: 8'h01, ec: 8'h7F, ed: 8'hFE};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {out_a, out_b, out_c, out_d}, 32'h0);
    chk("rst_flags", {29'd0, word_valid, locked, sync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    chk("idle_unlocked", {31'd0, locked}, 32'd0);

    // Word vectors, sent back to back. Some have random din_valid gaps.
    for (int v = 0; v < 5; v++) begin
      full_word($sformatf("vec%0d", v), vecs[v].w, vecs[v].gap,
                {vecs[v].ea, vecs[v].eb, vecs[v].ec, vecs[v].ed});
      repeat (3) step(1'($urandom), 1'b0, 1'($urandom));
      chk_outs($sformatf("vec%0d_hold", v), {vecs[v].ea, vecs[v].eb, vecs[v].ec, vecs[v].ed});
    end

    // Early marker on slot 2 of frame 4; realign and decode a fresh word.
    wv0 = n_wv;
    er0 = n_err;
    send_samples(32'h11223344, 1, 0, 14);
    chk("early_no_wv", n_wv - wv0, 32'd0);
    send_samples(32'hC35A9669, 0, 0, 1);
    chk("early_err", {31'd0, sync_err}, 32'd1);
    chk("early_locked", {31'd0, locked}, 32'd1);
    chk_outs("early_prev_hold", 32'h80017FFE);
    send_samples(32'hC35A9669, 0, 1, 32);
    chk("early_wv", {31'd0, word_valid}, 32'd1);
    chk_outs("early_new", 32'hC35A9669);
    step(1'b0, 1'b0, 1'b0);
    chk("early_err_count", n_err - er0, 32'd1);
    chk("early_wv_count", n_wv - wv0, 32'd1);

    // Missing marker at slot 0 of frame 3.
    send_samples(32'h55AA55AA, 0, 0, 8);
    step(1'b1, 1'b1, 1'b0);
    chk("miss_err", {31'd0, sync_err}, 32'd1);
    chk("miss_unlocked", {31'd0, locked}, 32'd0);
    chk("miss_no_wv", {31'd0, word_valid}, 32'd0);
    chk_outs("miss_prev_hold", 32'hC35A9669);
    step(1'b0, 1'b0, 1'b0);
    chk("miss_err_drop", {31'd0, sync_err}, 32'd0);
    full_word("relock", 32'h0F1E2D3C, 0, 32'h0F1E2D3C);

    // Reset after frame 5, asserted between clock edges.
    send_samples(32'hFFFFFFFF, 0, 0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {out_a, out_b, out_c, out_d}, 32'h0);
    chk("async_rst_flags", {29'd0, word_valid, locked, sync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Garbage without a marker in HUNT: must be ignored.
    wv0 = n_wv;
    er0 = n_err;
    for (int i = 0; i < 13; i++) step(1'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("garbage_unlocked", {31'd0, locked}, 32'd0);
    chk("garbage_wv", n_wv - wv0, 32'd0);
    chk("garbage_err", n_err - er0, 32'd0);
    chk_outs("garbage_outs", 32'h0);
    full_word("post_reset", 32'h01234567, 3, 32'h01234567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
